// File: rtl/alu_op_sequencer.sv
// Three-state (IDLE/EXEC/WB) micro-sequencer that drives every control input of the register-file/ALU datapath.
// Optional zero flag and skip-if-zero behaviour are enabled with the SEQ_ZERO_FLAG_EN macro.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
`ifdef SEQ_ZERO_FLAG_EN
  input  logic                  skip_if_zero,
  output logic                  zero_flag,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [1:0]            instr_op,
  input  logic                  instr_alu_mode,
  input  logic [3:0]            instr_alu_sel,
  input  logic [1:0]            instr_cin_sel,
  input  logic                  instr_wb,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_cout,
  output logic [ADDR_WIDTH-1:0] reg_read_addr1,
  output logic [ADDR_WIDTH-1:0] reg_read_addr2,
  output logic [ADDR_WIDTH-1:0] reg_write_addr,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  reg_write_enable,
  output logic                  b_source_select,
  output logic                  alu_cin,
  output logic                  alu_mode,
  output logic [3:0]            alu_sel,
  output logic [DATA_WIDTH-1:0] alu_b_imm,
  output logic                  carry_flag,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                state, state_next;
  logic [1:0]            ir_op;
  logic                  ir_mode;
  logic [3:0]            ir_sel;
  logic [1:0]            ir_cin_sel;
  logic                  ir_wb;
  logic [ADDR_WIDTH-1:0] ir_rd, ir_rs1, ir_rs2;
  logic [DATA_WIDTH-1:0] ir_imm;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  carry_q;
  logic                  skip_q;
  logic                  accept;
  logic                  is_alu_op;

  assign instr_ready = (state == IDLE);
  assign busy        = !instr_ready;
  assign accept      = instr_valid && instr_ready;
  assign carry_flag  = carry_q;
  assign is_alu_op   = (ir_op == 2'b00) || (ir_op == 2'b01);

`ifdef SEQ_ZERO_FLAG_EN
  logic zero_q;
  assign zero_flag = zero_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ir_op      <= '0;
      ir_mode    <= 1'b0;
      ir_sel     <= '0;
      ir_cin_sel <= '0;
      ir_wb      <= 1'b0;
      ir_rd      <= '0;
      ir_rs1     <= '0;
      ir_rs2     <= '0;
      ir_imm     <= '0;
      result_reg <= '0;
      carry_q    <= 1'b0;
      skip_q     <= 1'b0;
`ifdef SEQ_ZERO_FLAG_EN
      zero_q     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        ir_op      <= instr_op;
        ir_mode    <= instr_alu_mode;
        ir_sel     <= instr_alu_sel;
        ir_cin_sel <= instr_cin_sel;
        ir_wb      <= instr_wb;
        ir_rd      <= instr_rd;
        ir_rs1     <= instr_rs1;
        ir_rs2     <= instr_rs2;
        ir_imm     <= instr_imm;
`ifdef SEQ_ZERO_FLAG_EN
        // Skip decision uses the zero flag as it stands when the instruction is taken.
        skip_q     <= skip_if_zero && zero_q;
`else
        skip_q     <= 1'b0;
`endif
      end
      if (state == EXEC) begin
        if (is_alu_op) begin
          result_reg <= alu_result;
          if (!skip_q) begin
            carry_q <= alu_cout;
`ifdef SEQ_ZERO_FLAG_EN
            zero_q  <= (alu_result == '0);
`endif
          end
        end else if (ir_op == 2'b10) begin
          result_reg <= ir_imm;
        end
      end
    end
  end

  always_comb begin
    state_next       = state;
    reg_read_addr1   = '0;
    reg_read_addr2   = '0;
    reg_write_addr   = '0;
    reg_write_data   = '0;
    reg_write_enable = 1'b0;
    b_source_select  = 1'b0;
    alu_cin          = 1'b0;
    alu_mode         = 1'b0;
    alu_sel          = '0;
    alu_b_imm        = '0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) state_next = EXEC;
      end
      EXEC: begin
        state_next      = WB;
        reg_read_addr1  = ir_rs1;
        reg_read_addr2  = ir_rs2;
        alu_mode        = ir_mode;
        alu_sel         = ir_sel;
        b_source_select = (ir_op == 2'b01);
        alu_b_imm       = ir_imm;
        case (ir_cin_sel)
          2'b00:   alu_cin = 1'b0;
          2'b01:   alu_cin = 1'b1;
          2'b10:   alu_cin = carry_q;
          default: alu_cin = !carry_q;
        endcase
      end
      WB: begin
        state_next     = IDLE;
        reg_write_addr = ir_rd;
        reg_write_data = result_reg;
        // Reset in this cycle discards the instruction, so no write may escape.
        reg_write_enable = ir_wb && (ir_op != 2'b11) && !skip_q && !reset;
        done             = !reset;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench for alu_op_sequencer with a behavioural register-file/ALU datapath attached.
module tb_alu_op_sequencer;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic          instr_alu_mode;
  logic [3:0]    instr_alu_sel;
  logic [1:0]    instr_cin_sel;
  logic          instr_wb;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic [DW-1:0] instr_imm;
  logic [DW-1:0] alu_result;
  logic          alu_cout;
  logic [AW-1:0] reg_read_addr1, reg_read_addr2, reg_write_addr;
  logic [DW-1:0] reg_write_data;
  logic          reg_write_enable, b_source_select, alu_cin, alu_mode;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_b_imm;
  logic          carry_flag, busy, done;
`ifdef SEQ_ZERO_FLAG_EN
  logic          skip_if_zero = 1'b0;
  logic          zero_flag;
`endif

  alu_op_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(8)) dut (
`ifdef SEQ_ZERO_FLAG_EN
    .skip_if_zero(skip_if_zero), .zero_flag(zero_flag),
`endif
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_alu_mode(instr_alu_mode), .instr_alu_sel(instr_alu_sel),
    .instr_cin_sel(instr_cin_sel), .instr_wb(instr_wb), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .reg_read_addr1(reg_read_addr1), .reg_read_addr2(reg_read_addr2),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .reg_write_enable(reg_write_enable), .b_source_select(b_source_select),
    .alu_cin(alu_cin), .alu_mode(alu_mode), .alu_sel(alu_sel), .alu_b_imm(alu_b_imm),
    .carry_flag(carry_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 74181-like behaviour with active-low carry in/out in arithmetic mode.
  function automatic logic [DW:0] alu_fn(input logic m, input logic [3:0] s,
                                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic c);
    logic [DW:0] t;
    if (m) begin
      case (s)
        4'b0000: t = {1'b1, ~a};
        4'b0110: t = {1'b1, a ^ b};
        4'b1011: t = {1'b1, a & b};
        4'b1110: t = {1'b1, a | b};
        default: t = {1'b1, a};
      endcase
    end else begin
      if (s == 4'b1001) t = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, !c};
      else              t = {1'b0, a} + {{DW{1'b0}}, !c};
      t[DW] = !t[DW];
    end
    return t;
  endfunction

  // Environment datapath: register file plus ALU, driven by the sequencer's outputs.
  logic [DW-1:0] rf [8] = '{default: '0};
  always_comb {alu_cout, alu_result} = alu_fn(alu_mode, alu_sel, rf[reg_read_addr1],
                                              b_source_select ? alu_b_imm : rf[reg_read_addr2], alu_cin);
  always @(posedge clk) if (reg_write_enable) rf[reg_write_addr] <= reg_write_data;

  typedef struct {
    logic [AW-1:0] rs1, rs2, rd;
    logic          bsel, cin, mode, we, carry;
    logic [3:0]    sel;
    logic [DW-1:0] imm, data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mreg [8] = '{default: '0};
  logic [DW-1:0] mres = '0;
  logic          mcarry = 1'b0;
  int            total = 0, bad = 0, cyc = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  // Reference model: applies one instruction's architectural effect.
  task automatic model_push(input logic [1:0] op, input logic m, input logic [3:0] s,
                            input logic [1:0] cs, input logic wb, input logic [AW-1:0] rd,
                            input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [DW-1:0] imm);
    exp_t e;
    logic [DW:0] r;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = imm; e.mode = m; e.sel = s;
    e.bsel = (op == 2'd1);
    e.cin  = (cs == 2'd0) ? 1'b0 : (cs == 2'd1) ? 1'b1 : (cs == 2'd2) ? mcarry : !mcarry;
    r = alu_fn(m, s, mreg[r1], (op == 2'd1) ? imm : mreg[r2], e.cin);
    if (op <= 2'd1) begin mres = r[DW-1:0]; mcarry = r[DW]; end
    else if (op == 2'd2) mres = imm;
    e.we = wb && (op != 2'd3);
    if (e.we) mreg[rd] = mres;
    e.data = mres; e.carry = mcarry;
    q.push_back(e);
  endtask

  int acc_cyc;
  // Called at a negedge; returns at the negedge after the accepting edge (EXEC cycle).
  task automatic send(input logic [1:0] op, input logic m, input logic [3:0] s,
                      input logic [1:0] cs, input logic wb, input logic [AW-1:0] rd,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic [DW-1:0] imm, input bit hold);
    int n = 0;
    instr_op = op; instr_alu_mode = m; instr_alu_sel = s; instr_cin_sel = cs; instr_wb = wb;
    instr_rd = rd; instr_rs1 = r1; instr_rs2 = r2; instr_imm = imm; instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      chk("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    model_push(op, m, s, cs, wb, rd, r1, r2, imm);
    acc_cyc = cyc;
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (busy && !done) begin
        if (q.size() == 0) chk("exec_unexpected", 32'd1, 32'd0);
        else begin
          me = q[0];
          chk("exec_rs1", 32'(reg_read_addr1), 32'(me.rs1));
          chk("exec_rs2", 32'(reg_read_addr2), 32'(me.rs2));
          chk("exec_bsel", 32'(b_source_select), 32'(me.bsel));
          chk("exec_imm", 32'(alu_b_imm), 32'(me.imm));
          chk("exec_cin", 32'(alu_cin), 32'(me.cin));
          chk("exec_mode_sel", {27'd0, alu_mode, alu_sel}, {27'd0, me.mode, me.sel});
          chk("exec_we", 32'(reg_write_enable), 32'd0);
        end
      end else if (done) begin
        if (q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          me = q.pop_front();
          chk("wb_we", 32'(reg_write_enable), 32'(me.we));
          chk("wb_addr", 32'(reg_write_addr), 32'(me.rd));
          chk("wb_data", 32'(reg_write_data), 32'(me.data));
          chk("wb_carry", 32'(carry_flag), 32'(me.carry));
          chk("wb_busy", 32'(busy), 32'd1);
        end
      end else begin
        chk("idle_we", 32'(reg_write_enable), 32'd0);
        chk("idle_dp", {alu_b_imm, 4'(alu_sel), 3'(reg_read_addr1), 3'(reg_read_addr2),
                        alu_cin, alu_mode}, 32'd0);
      end
    end
  end

  logic [3:0]    sels [4] = '{4'b1001, 4'b0110, 4'b1011, 4'b1110};
  logic [DW-1:0] sv_reg [8];
  int            prev_cyc, n;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_alu_mode = 1'b0; instr_alu_sel = '0;
    instr_cin_sel = '0; instr_wb = 1'b0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_flags", {29'd0, busy, done, carry_flag}, 32'd0);
    chk("rst_dp", {15'd0, reg_write_enable, reg_write_data}, 32'd0);
    mon_en = 1'b1;

    send(2'd2, 1'b0, 4'd0, 2'd0, 1'b1, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b0);
    send(2'd2, 1'b0, 4'd0, 2'd0, 1'b1, 3'd2, 3'd0, 3'd0, 16'h0101, 1'b0);
    send(2'd0, 1'b0, 4'b1001, 2'd1, 1'b1, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
    send(2'd1, 1'b1, 4'b0110, 2'd0, 1'b1, 3'd4, 3'd1, 3'd0, 16'h00FF, 1'b0);
    repeat (3) @(negedge clk);
    chk("ldi_r1", 32'(rf[1]), 32'h1234);
    chk("ldi_r2", 32'(rf[2]), 32'h0101);
    chk("add_r3", 32'(rf[3]), 32'h1335);
    chk("xor_r4", 32'(rf[4]), 32'h12CB);

    // Carry chain: 0xFFFF + 1 carries out (active-low cout = 0), then reuse the flag.
    send(2'd2, 1'b0, 4'd0, 2'd0, 1'b1, 3'd6, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    send(2'd2, 1'b0, 4'd0, 2'd0, 1'b1, 3'd7, 3'd0, 3'd0, 16'h0001, 1'b0);
    send(2'd0, 1'b0, 4'b1001, 2'd1, 1'b1, 3'd0, 3'd6, 3'd7, 16'h0000, 1'b0);
    send(2'd0, 1'b0, 4'b1001, 2'd2, 1'b1, 3'd5, 3'd7, 3'd7, 16'h0000, 1'b0);
    send(2'd0, 1'b0, 4'b1001, 2'd3, 1'b1, 3'd5, 3'd7, 3'd7, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("chain_r0", 32'(rf[0]), 32'h0000);

    // Valid held high with wb=0 and NOPs: one accept every 3 cycles, never a write.
    send(2'd3, 1'b0, 4'd0, 2'd0, 1'b0, 3'd2, 3'd1, 3'd1, 16'hAAAA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      prev_cyc = acc_cyc;
      send(2'd3, 1'b0, 4'd0, 2'd0, 1'b0, 3'd2, 3'd1, 3'd1, 16'hAAAA, 1'b1);
      chk("nop_spacing", 32'(acc_cyc - prev_cyc), 32'd3);
    end
    instr_valid = 1'b0;

    for (int i = 0; i < 60; i++)
      send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sels[$urandom_range(0, 3)],
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
    instr_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", 32'(q.size()), 32'd0);

    // Reset during EXEC of an ALU op targeting r5: no write, clean state afterwards.
    send(2'd2, 1'b0, 4'd0, 2'd0, 1'b1, 3'd5, 3'd0, 3'd0, 16'h5A5A, 1'b0);
    repeat (3) @(negedge clk);
    sv_reg = mreg;
    mon_en = 1'b0;
    send(2'd0, 1'b0, 4'b1001, 2'd1, 1'b1, 3'd5, 3'd1, 3'd2, 16'h0000, 1'b0);
    reset = 1'b1;
    #1 chk("rst_exec_we", 32'(reg_write_enable), 32'd0);
    @(negedge clk);
    chk("rst_hold_we", {30'd0, reg_write_enable, done}, 32'd0);
    reset = 1'b0;
    q.delete(); mreg = sv_reg; mcarry = 1'b0; mres = '0;
    chk("rst_mid_ready", 32'(instr_ready), 32'd1);
    chk("rst_mid_flags", {30'd0, carry_flag, busy}, 32'd0);
    chk("rst_mid_dp", {alu_b_imm, reg_write_data}, 32'd0);
    chk("rst_mid_ctl", {24'd0, alu_sel, alu_cin, alu_mode, b_source_select, reg_write_enable}, 32'd0);
    @(negedge clk);
    chk("rst_no_r5", 32'(rf[5]), 32'h5A5A);
    mon_en = 1'b1;

    // After reset the carry is 0, so cin_sel 10 drives 0.
    send(2'd0, 1'b0, 4'b1001, 2'd2, 1'b1, 3'd5, 3'd6, 3'd7, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), 32'(rf[i]), 32'(mreg[i]));
    chk("final_q", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle micro-sequencer that drives the register-file/74181-ALU datapath top (cpu_top).
- Accepts one decoded instruction per valid/ready handshake and sequences it: register read and ALU evaluate, result latch, write-back.
- Holds a carry flag so chained multi-word arithmetic can feed the previous carry into alu_cin.
- Sits between an instruction source (testbench, ROM walker, host) and cpu_top; owns every datapath control input.

Parameters:
- DATA_WIDTH, 16, datapath and immediate width.
- NUM_REGS, 8, register count.
- ADDR_WIDTH, $clog2(NUM_REGS), register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept
- instr_op  in  2  00 ALU reg-reg, 01 ALU reg-imm, 10 load-immediate, 11 NOP
- instr_alu_mode  in  1  ALU mode (1 = logic)
- instr_alu_sel  in  4  ALU function select
- instr_cin_sel  in  2  00 const 0, 01 const 1, 10 carry_flag, 11 ~carry_flag
- instr_wb  in  1  write result to rd
- instr_rd, instr_rs1, instr_rs2  in  ADDR_WIDTH each  destination and sources
- instr_imm  in  DATA_WIDTH  immediate
- alu_result  in  DATA_WIDTH  from datapath
- alu_cout  in  1  from datapath
- reg_read_addr1, reg_read_addr2  out  ADDR_WIDTH  to datapath
- reg_write_addr  out  ADDR_WIDTH  to datapath
- reg_write_data  out  DATA_WIDTH  to datapath
- reg_write_enable  out  1  to datapath
- b_source_select  out  1  to datapath
- alu_cin, alu_mode  out  1 each  to datapath
- alu_sel  out  4  to datapath
- alu_b_imm  out  DATA_WIDTH  to datapath
- carry_flag  out  1  stored carry
- busy  out  1  not in IDLE
- done  out  1  one-cycle pulse, instruction retired

Behaviour:
- States: IDLE, EXEC, WB.
  - IDLE→EXEC on instr_valid & instr_ready. All instr_* fields are latched into an instruction register on that edge.
  - EXEC→WB unconditionally.
  - WB→IDLE unconditionally.
- Timing: accept at edge N; EXEC is cycle N+1; WB is cycle N+2; instr_ready is high again in cycle N+3. Fixed 3-cycle throughput with no overlap.
- instr_ready = (state == IDLE). busy = !instr_ready.
- EXEC cycle outputs, all driven from latched fields:
  - reg_read_addr1 = rs1, reg_read_addr2 = rs2.
  - alu_mode and alu_sel from the latched fields.
  - b_source_select = (op == 01); alu_b_imm = imm.
  - alu_cin per cin_sel, using carry_flag as it stood at the start of EXEC.
  - At the end of EXEC:
    - ALU ops (00/01): result_reg ← alu_result and carry_flag ← alu_cout (raw polarity, no inversion).
    - LDI: result_reg ← imm; carry_flag unchanged.
    - NOP: nothing is latched.
- WB cycle outputs:
  - reg_write_addr = rd; reg_write_data = result_reg.
  - reg_write_enable = wb & (op != 11).
  - done = 1.
- Outside the relevant states, all datapath outputs are 0: addresses, alu_sel, alu_mode, alu_cin, b_source_select, alu_b_imm, reg_write_data, reg_write_enable.
- rd equal to rs1/rs2: legal. The read occurs in EXEC and the write in WB, so no hazard. Back-to-back dependent instructions see the written value because the write commits before the next EXEC.
- instr_valid while busy is ignored; the source must hold its fields until accepted.
- Reset, including mid-instruction:
  - Next state IDLE; instruction and result registers cleared; carry_flag = 0.
  - All outputs 0 except instr_ready = 1.
  - An instruction in EXEC or WB is discarded with no write; a write is never issued in the cycle reset is high.
  - Register-file contents are governed by the datapath's own reset.

Optional Feature:
- Macro SEQ_ZERO_FLAG_EN.
- When defined:
  - Adds a zero_flag output (1 bit) and a skip_if_zero input (1 bit, latched with the instruction).
  - zero_flag ← (alu_result == 0) at the end of EXEC for ALU ops; cleared on reset.
  - If latched skip_if_zero = 1 and zero_flag = 1 at accept time, the instruction still takes 3 cycles and pulses done, but reg_write_enable and flag updates are suppressed.
- When undefined: neither port exists and there is no skip behaviour.

Test Plan:
- Reset, then LDI r1=0x1234 and LDI r2=0x0101 → reg_write_enable high exactly in cycle N+2 with addr 1/data 0x1234, then 2/0x0101; done pulses 1 cycle each; carry_flag stays 0.
- ALU reg-reg, mode 0, sel 1001, cin_sel 01, rs1=1, rs2=2, rd=3 → EXEC drives addrs 1/2 and b_source_select 0; WB writes r3=0x1335.
- ALU reg-imm, mode 1, sel 0110, imm 0x00FF, rs1=1, rd=4 → b_source_select 1 in EXEC only; WB writes r4=0x12CB.
- Carry chain: 0xFFFF + 0x0001 with cin_sel 01 → carry_flag latches alu_cout. Next op with cin_sel 10 drives alu_cin = carry_flag in EXEC; with cin_sel 11 it drives the inverse.
- instr_valid held high continuously with wb=0 and a NOP → accepts every 3 cycles only; no reg_write_enable; done still pulses.
- Assert reset during the EXEC of an ALU op with rd=5 → no write to r5; next cycle instr_ready=1, carry_flag=0, all datapath outputs 0.
